// File: rtl/alu4_seq_if.sv
// rtl/alu4_seq_if.sv - instruction and response valid/ready channels of alu4_seq
`timescale 1ns/1ps
interface alu4_seq_if #(
   parameter int WIDTH = 4,
   parameter int AW    = 2
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [AW-1:0]    in_ra;
   logic [AW-1:0]    in_rb;
   logic             in_imm_en;
   logic [WIDTH-1:0] in_imm;
   logic [AW-1:0]    in_rd;
   logic             in_wb_en;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [3:0]       out_flags;
   logic [AW-1:0]    out_rd;

   modport master (
      output in_valid, in_op, in_ra, in_rb, in_imm_en, in_imm, in_rd, in_wb_en,
      input  in_ready,
      input  out_valid, out_result, out_flags, out_rd,
      output out_ready
   );

   modport slave (
      input  in_valid, in_op, in_ra, in_rb, in_imm_en, in_imm, in_rd, in_wb_en,
      output in_ready,
      output out_valid, out_result, out_flags, out_rd,
      input  out_ready
   );
endinterface

// File: rtl/alu4_seq.sv
// rtl/alu4_seq.sv - operand sequencer, register file and writeback around the combinational alu4
`timescale 1ns/1ps
module alu4_seq #(
   parameter int  WIDTH    = 4,
   parameter int  NUM_REGS = 4,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             reset_n,
   alu4_seq_if.slave        bus,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_c,
   input  logic             alu_n,
   input  logic             alu_z,
   input  logic             alu_v,
   input  logic [AW-1:0]    dbg_sel,
   output logic [WIDTH-1:0] dbg_data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] regs [NUM_REGS];
   logic [AW-1:0]    rd_q;
   logic             wb_en_q;
   logic             accept;

   assign accept   = (state == S_IDLE) && bus.in_valid;
   assign dbg_data = regs[dbg_sel];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      bus.in_ready = 1'b0;
      case (state)
         S_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nx = S_EXEC;
         end
         S_EXEC: state_nx = S_RESP;
         S_RESP: if (bus.out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Operands are read only in IDLE, after any writeback, so no forwarding is needed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alu_a          <= '0;
         alu_b          <= '0;
         alu_op         <= '0;
         rd_q           <= '0;
         wb_en_q        <= 1'b0;
         bus.out_valid  <= 1'b0;
         bus.out_result <= '0;
         bus.out_flags  <= '0;
         bus.out_rd     <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         if (accept) begin
            alu_a   <= regs[bus.in_ra];
            alu_b   <= bus.in_imm_en ? bus.in_imm : regs[bus.in_rb];
            alu_op  <= bus.in_op;
            rd_q    <= bus.in_rd;
            wb_en_q <= bus.in_wb_en;
         end
         if (state == S_EXEC) begin
            bus.out_result <= alu_result;
            bus.out_flags  <= {alu_n, alu_z, alu_c, alu_v};
            bus.out_rd     <= rd_q;
            bus.out_valid  <= 1'b1;
            if (wb_en_q) regs[rd_q] <= alu_result;
         end
         if ((state == S_RESP) && bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end

endmodule
